// File: rtl/cb_douta_router.sv
// cb_douta_router: routes CB port-a read lanes onto the A, B or M output bus.
// A burst of len beats is launched by start. Each beat's CB data is rotated
// (POS), reversed (REV) or taken as a fixed lane pair (NEW) and presented on
// the selected destination as a registered, one-cycle-per-beat valid stream.
// Optional feature macro: CB_ROUTE_REV_EN enables the reverse lane mapping
// (dir=10); without it dir=10 bursts run but produce no data.
module cb_douta_router #(
    parameter int L      = 4,
    parameter int X      = 4,
    parameter int Y      = 4,
    parameter int RSA_DW = 16,
    parameter int RD_LAT = 1,
    parameter int LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [1:0]            dest,
    input  logic [1:0]            dir,
    input  logic [$clog2(L)-1:0]  offset,
    input  logic [$clog2(L):0]    nlanes,
    input  logic [LEN_W-1:0]      len,
    input  logic                  flush,
    input  logic [L*RSA_DW-1:0]   CB_douta,
    output logic [X*RSA_DW-1:0]   A_CB_douta,
    output logic                  A_vld,
    output logic [Y*RSA_DW-1:0]   B_CB_douta,
    output logic                  B_vld,
    output logic [X*RSA_DW-1:0]   M_CB_douta,
    output logic                  M_vld,
    output logic                  busy,
    output logic                  done
);

    localparam int OFF_W = $clog2(L);
    localparam int NL_W  = OFF_W + 1;

    localparam logic [1:0] DEST_A  = 2'b01;
    localparam logic [1:0] DEST_B  = 2'b10;
    localparam logic [1:0] DEST_M  = 2'b11;
    localparam logic [1:0] DIR_POS = 2'b01;
    localparam logic [1:0] DIR_REV = 2'b10;
    localparam logic [1:0] DIR_NEW = 2'b11;

    // WAIT burns RD_LAT-1 cycles; the counter starts one below that because
    // the exit decision is taken on the cycle the counter reads zero.
    localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            dest_q, dest_d;
    logic [1:0]            dir_q, dir_d;
    logic [OFF_W-1:0]      offset_q, offset_d;
    logic [NL_W-1:0]       nlanes_q, nlanes_d;
    logic [LEN_W-1:0]      beats_q, beats_d;
    logic [1:0]            wait_q, wait_d;
    logic [X*RSA_DW-1:0]   a_data_q, a_data_d;
    logic                  a_vld_q, a_vld_d;
    logic [Y*RSA_DW-1:0]   b_data_q, b_data_d;
    logic                  b_vld_q, b_vld_d;
    logic [X*RSA_DW-1:0]   m_data_q, m_data_d;
    logic                  m_vld_q, m_vld_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [RSA_DW-1:0]     cb_lane [L];
    logic [X*RSA_DW-1:0]   x_route;
    logic [Y*RSA_DW-1:0]   y_route;
    logic                  route_en;
    logic [OFF_W-1:0]      src_x, src_y;
    int                    n_all, n_x, n_y;

    // Split the flat CB read bus into addressable lanes.
    always_comb begin
        for (int j = 0; j < L; j++) begin
            cb_lane[j] = CB_douta[j*RSA_DW +: RSA_DW];
        end
    end

    // Lane mapping from the captured config; lanes beyond the effective count stay zero.
    always_comb begin
        x_route  = '0;
        y_route  = '0;
        route_en = 1'b0;
        src_x    = '0;
        src_y    = '0;
        case (dir_q)
            DIR_POS, DIR_NEW: route_en = 1'b1;
`ifdef CB_ROUTE_REV_EN
            DIR_REV:          route_en = 1'b1;
`endif
            default:          route_en = 1'b0;
        endcase
        if (dir_q == DIR_NEW) begin
            n_all = 2;
        end else if (int'(nlanes_q) > L) begin
            n_all = L;
        end else begin
            n_all = int'(nlanes_q);
        end
        n_x = (n_all > X) ? X : n_all;
        n_y = (n_all > Y) ? Y : n_all;
        for (int i = 0; i < X; i++) begin
            src_x = offset_q + OFF_W'(i);
`ifdef CB_ROUTE_REV_EN
            if (dir_q == DIR_REV) begin
                src_x = offset_q + OFF_W'(n_x - 1 - i);
            end
`endif
            if (i < n_x) begin
                x_route[i*RSA_DW +: RSA_DW] = cb_lane[src_x];
            end
        end
        for (int i = 0; i < Y; i++) begin
            src_y = offset_q + OFF_W'(i);
`ifdef CB_ROUTE_REV_EN
            if (dir_q == DIR_REV) begin
                src_y = offset_q + OFF_W'(n_y - 1 - i);
            end
`endif
            if (i < n_y) begin
                y_route[i*RSA_DW +: RSA_DW] = cb_lane[src_y];
            end
        end
    end

    // Burst sequencing: capture on start, wait out read latency, stream len beats.
    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        dir_d    = dir_q;
        offset_d = offset_q;
        nlanes_d = nlanes_q;
        beats_d  = beats_q;
        wait_d   = wait_q;
        a_data_d = '0;
        a_vld_d  = 1'b0;
        b_data_d = '0;
        b_vld_d  = 1'b0;
        m_data_d = '0;
        m_vld_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (len != '0) && !busy_q) begin
                    dest_d   = dest;
                    dir_d    = dir;
                    offset_d = offset;
                    nlanes_d = nlanes;
                    beats_d  = len;
                    wait_d   = WAIT_INIT;
                    state_d  = (RD_LAT == 1) ? S_STREAM : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    busy_d = 1'b1;
                    if (wait_q == 2'd0) begin
                        state_d = S_STREAM;
                    end else begin
                        wait_d = wait_q - 2'd1;
                    end
                end
            end
            S_STREAM: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    busy_d = 1'b1;
                    if (route_en) begin
                        case (dest_q)
                            DEST_A: begin
                                a_data_d = x_route;
                                a_vld_d  = 1'b1;
                            end
                            DEST_B: begin
                                b_data_d = y_route;
                                b_vld_d  = 1'b1;
                            end
                            DEST_M: begin
                                m_data_d = x_route;
                                m_vld_d  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    if (beats_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        beats_d = beats_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured config and registered outputs; reset clears everything.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            dest_q   <= '0;
            dir_q    <= '0;
            offset_q <= '0;
            nlanes_q <= '0;
            beats_q  <= '0;
            wait_q   <= '0;
            a_data_q <= '0;
            a_vld_q  <= 1'b0;
            b_data_q <= '0;
            b_vld_q  <= 1'b0;
            m_data_q <= '0;
            m_vld_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            dir_q    <= dir_d;
            offset_q <= offset_d;
            nlanes_q <= nlanes_d;
            beats_q  <= beats_d;
            wait_q   <= wait_d;
            a_data_q <= a_data_d;
            a_vld_q  <= a_vld_d;
            b_data_q <= b_data_d;
            b_vld_q  <= b_vld_d;
            m_data_q <= m_data_d;
            m_vld_q  <= m_vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign A_CB_douta = a_data_q;
    assign A_vld      = a_vld_q;
    assign B_CB_douta = b_data_q;
    assign B_vld      = b_vld_q;
    assign M_CB_douta = m_data_q;
    assign M_vld      = m_vld_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_cb_douta_router.sv
// Self-checking bench for cb_douta_router (L=X=Y=4, RSA_DW=16).
// Main instance uses RD_LAT=1; a second instance with RD_LAT=3 checks latency.
module tb_cb_douta_router;

    localparam logic [63:0] CB_C = 64'h0044_0033_0022_0011;
`ifdef CB_ROUTE_REV_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [1:0]  dest;
    logic [1:0]  dir;
    logic [1:0]  offset;
    logic [2:0]  nlanes;
    logic [7:0]  len;
    logic        flush;
    logic [63:0] cbDouta;

    logic [63:0] aData, bData, mData;
    logic        aVld, bVld, mVld, busyO, doneO;
    logic [63:0] aData3, bData3, mData3;
    logic        aVld3, bVld3, mVld3, busyO3, doneO3;

    typedef struct packed {
        logic [63:0] a;
        logic        av;
        logic [63:0] b;
        logic        bv;
        logic [63:0] m;
        logic        mv;
        logic        busy;
        logic        done;
    } obs_t;

    typedef struct {
        logic [1:0]  dest;
        logic [1:0]  dir;
        logic [1:0]  offset;
        logic [2:0]  nl;
        logic [7:0]  len;
        logic [63:0] data;
        logic        vld;
    } vec_t;

    vec_t vecs [9];
    obs_t expQ [$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    cb_douta_router dut (
        .clk(clk), .sys_rst(sys_rst), .start(start), .dest(dest), .dir(dir),
        .offset(offset), .nlanes(nlanes), .len(len), .flush(flush), .CB_douta(cbDouta),
        .A_CB_douta(aData), .A_vld(aVld), .B_CB_douta(bData), .B_vld(bVld),
        .M_CB_douta(mData), .M_vld(mVld), .busy(busyO), .done(doneO)
    );

    cb_douta_router #(.RD_LAT(3)) dut3 (
        .clk(clk), .sys_rst(sys_rst), .start(start), .dest(dest), .dir(dir),
        .offset(offset), .nlanes(nlanes), .len(len), .flush(flush), .CB_douta(cbDouta),
        .A_CB_douta(aData3), .A_vld(aVld3), .B_CB_douta(bData3), .B_vld(bVld3),
        .M_CB_douta(mData3), .M_vld(mVld3), .busy(busyO3), .done(doneO3)
    );

    function automatic obs_t obsMain();
        return {aData, aVld, bData, bVld, mData, mVld, busyO, doneO};
    endfunction

    function automatic obs_t obsLat3();
        return {aData3, aVld3, bData3, bVld3, mData3, mVld3, busyO3, doneO3};
    endfunction

    function automatic logic [63:0] pattern(input int k);
        logic [63:0] p;
        for (int j = 0; j < 4; j++) begin
            p[j*16 +: 16] = 16'(4096 * k + j + 1);
        end
        return p;
    endfunction

    // Expected observation for one beat of a vector
    function automatic obs_t beatOf(input vec_t v, input logic isLast);
        obs_t o;
        o      = '0;
        o.busy = 1'b1;
        o.done = isLast;
        if (v.vld) begin
            case (v.dest)
                2'b01: begin o.a = v.data; o.av = 1'b1; end
                2'b10: begin o.b = v.data; o.bv = 1'b1; end
                2'b11: begin o.m = v.data; o.mv = 1'b1; end
                default: ;
            endcase
        end
        return o;
    endfunction

    task automatic checkObs(input string name, input obs_t act, input obs_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got a=%h/%b b=%h/%b m=%h/%b busy=%b done=%b | want a=%h/%b b=%h/%b m=%h/%b busy=%b done=%b",
                     name, act.a, act.av, act.b, act.bv, act.m, act.mv, act.busy, act.done,
                     exp.a, exp.av, exp.b, exp.bv, exp.m, exp.mv, exp.busy, exp.done);
        end
    endtask

    // Drive one start pulse and queue the beats it should produce
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        dest   = v.dest;
        dir    = v.dir;
        offset = v.offset;
        nlanes = v.nl;
        len    = v.len;
        start  = 1'b1;
        for (int k = 0; k < int'(v.len); k++) begin
            expQ.push_back(beatOf(v, k == int'(v.len) - 1));
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Pop and compare one queued beat per cycle, then require a quiet bus
    task automatic checkOutput(input string name);
        checkObs({name, "_e0"}, obsMain(), '0);
        while (expQ.size() > 0) begin
            @(negedge clk);
            checkObs(name, obsMain(), expQ.pop_front());
        end
        @(negedge clk);
        checkObs({name, "_end"}, obsMain(), '0);
    endtask

    initial begin
        obs_t e;
        vec_t v;
        obs_t lat3Exp [5];

        vecs[0] = '{2'b01, 2'b01, 2'd1, 3'd4, 8'd3, 64'h0011_0044_0033_0022, 1'b1};
        vecs[1] = '{2'b10, 2'b10, 2'd2, 3'd3, 8'd1,
                    REV_EN ? 64'h0000_0033_0044_0011 : 64'h0, REV_EN};
        vecs[2] = '{2'b11, 2'b11, 2'd3, 3'd4, 8'd2, 64'h0000_0000_0011_0044, 1'b1};
        vecs[3] = '{2'b01, 2'b01, 2'd0, 3'd0, 8'd1, 64'h0, 1'b1};
        vecs[4] = '{2'b10, 2'b01, 2'd2, 3'd7, 8'd2, 64'h0022_0011_0044_0033, 1'b1};
        vecs[5] = '{2'b01, 2'b00, 2'd0, 3'd4, 8'd2, 64'h0, 1'b0};
        vecs[6] = '{2'b00, 2'b01, 2'd0, 3'd4, 8'd1, 64'h0, 1'b0};
        vecs[7] = '{2'b11, 2'b01, 2'd3, 3'd2, 8'd1, 64'h0000_0000_0011_0044, 1'b1};
        vecs[8] = '{2'b01, 2'b10, 2'd0, 3'd2, 8'd1,
                    REV_EN ? 64'h0000_0000_0011_0022 : 64'h0, REV_EN};

        sys_rst = 1'b1;
        start   = 1'b0;
        dest    = '0;
        dir     = '0;
        offset  = '0;
        nlanes  = '0;
        len     = '0;
        flush   = 1'b0;
        cbDouta = CB_C;
        #1;
        checkObs("reset_main", obsMain(), '0);
        checkObs("reset_lat3", obsLat3(), '0);
        @(negedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        checkObs("after_reset", obsMain(), '0);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // len=0 start is ignored
        v = '{2'b01, 2'b01, 2'd0, 3'd4, 8'd0, 64'h0, 1'b1};
        applyStimulus(v);
        checkObs("len0_e0", obsMain(), '0);
        @(negedge clk);
        checkObs("len0_e1", obsMain(), '0);

        // Per-beat sampling: CB data changes every cycle
        @(negedge clk);
        dest = 2'b01; dir = 2'b01; offset = 2'd0; nlanes = 3'd4; len = 8'd3; start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cbDouta = pattern(1);
        for (int k = 1; k <= 3; k++) begin
            e = '0; e.a = pattern(k); e.av = 1'b1; e.busy = 1'b1; e.done = (k == 3);
            expQ.push_back(e);
        end
        checkObs("tim_e0", obsMain(), '0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkObs($sformatf("tim_beat%0d", k), obsMain(), expQ.pop_front());
            cbDouta = pattern(k + 1);
        end
        @(negedge clk);
        checkObs("tim_end", obsMain(), '0);
        cbDouta = CB_C;

        // Flush after two beats of a len=5 burst
        v = '{2'b01, 2'b01, 2'd0, 3'd4, 8'd5, CB_C, 1'b1};
        applyStimulus(v);
        checkObs("flush_e0", obsMain(), '0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkObs($sformatf("flush_beat%0d", k), obsMain(), expQ.pop_front());
        end
        expQ.delete();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkObs("flush_clear", obsMain(), '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkObs($sformatf("flush_quiet%0d", k), obsMain(), '0);
        end

        // Start during busy is ignored, then reset mid-burst
        applyStimulus('{2'b01, 2'b01, 2'd1, 3'd4, 8'd5, 64'h0011_0044_0033_0022, 1'b1});
        dest = 2'b10; dir = 2'b01; offset = 2'd0; nlanes = 3'd4; len = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkObs("busy_beat0", obsMain(), expQ.pop_front());
        @(negedge clk);
        checkObs("busy_beat1", obsMain(), expQ.pop_front());
        expQ.delete();
        #2;
        sys_rst = 1'b1;
        #1;
        checkObs("midrst_main", obsMain(), '0);
        @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        checkObs("midrst_quiet", obsMain(), '0);

        // Fresh burst after reset behaves normally
        applyStimulus(vecs[0]);
        checkOutput("post_rst");

        // RD_LAT=3 instance: valid exactly on the third edge
        repeat (6) @(negedge clk);
        for (int k = 0; k < 5; k++) lat3Exp[k] = '0;
        lat3Exp[1].busy = 1'b1;
        lat3Exp[2].busy = 1'b1;
        lat3Exp[3].busy = 1'b1;
        lat3Exp[3].done = 1'b1;
        lat3Exp[3].a    = CB_C;
        lat3Exp[3].av   = 1'b1;
        dest = 2'b01; dir = 2'b01; offset = 2'd0; nlanes = 3'd4; len = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checkObs($sformatf("lat3_e%0d", k), obsLat3(), lat3Exp[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cb_douta_router.md
CB_DOUTA_ROUTER -- requirements
Module: cb_douta_router

Interface
REQ-001 Parameter L, default 4, CB read lanes (power of 2, >=2).
REQ-002 Parameter X, default 4, lanes of A and M outputs.
REQ-003 Parameter Y, default 4, lanes of B output.
REQ-004 Parameter RSA_DW, default 16, bits per lane.
REQ-005 Parameter RD_LAT, default 1, CB read latency in cycles (1..4).
REQ-006 Parameter LEN_W, default 8, burst-length counter width.
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 sys_rst  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  burst request pulse; CB address for beat 0 is issued upstream in the same cycle.
REQ-010 dest  input  2  01=A, 10=B, 11=M, 00=none.
REQ-011 dir  input  2  00=IDLE, 01=POS, 10=REV, 11=NEW.
REQ-012 offset  input  clog2(L)  first source lane.
REQ-013 nlanes  input  clog2(L)+1  active lane count.
REQ-014 len  input  LEN_W  beats in burst.
REQ-015 flush  input  1  synchronous burst abort.
REQ-016 CB_douta  input  L*RSA_DW  CB port-a read data, lane j at [j*RSA_DW +: RSA_DW].
REQ-017 A_CB_douta / A_vld  output  X*RSA_DW / 1  registered A data and valid.
REQ-018 B_CB_douta / B_vld  output  Y*RSA_DW / 1  registered B data and valid.
REQ-019 M_CB_douta / M_vld  output  X*RSA_DW / 1  registered M data and valid.
REQ-020 busy / done  output  1 / 1  burst in progress / one-cycle completion pulse.

Function
REQ-021 FSM states IDLE, WAIT, STREAM; all outputs registered.
REQ-022 IDLE: start=1 with len!=0 captures dest, dir, offset, nlanes, len and enters WAIT; start with len=0 is ignored.
REQ-023 WAIT lasts RD_LAT-1 cycles (zero for RD_LAT=1), then STREAM.
REQ-024 Beat k's CB_douta is sampled at the (RD_LAT+k)-th rising edge after the start edge; selected output and its _vld update at that edge.
REQ-025 STREAM produces exactly len consecutive beats, no bubbles; returns to IDLE after last beat.
REQ-026 done=1 in the same cycle as the last beat's _vld; never asserted otherwise.
REQ-027 busy=1 from the edge after start through the last beat cycle inclusive.
REQ-028 start while busy is ignored; captured config unchanged.
REQ-029 Effective lane count n = min(nlanes, L, output width); nlanes=0 yields all-zero data with _vld still asserted.
REQ-030 POS: output lane i (i<n) = CB lane (offset+i) mod L.
REQ-031 REV: output lane i (i<n) = CB lane (offset+n-1-i) mod L.
REQ-032 NEW: output lanes 0,1 = CB lanes offset, (offset+1) mod L; n forced to 2.
REQ-033 dir=IDLE or dest=00: burst runs (busy, done) but all data and _vld remain 0.
REQ-034 Output lanes i>=n are 0; non-selected destinations hold 0 data and _vld=0.
REQ-035 Any output with _vld=0 carries all-zero data.
REQ-036 flush=1 in WAIT/STREAM: next edge returns to IDLE, clears all outputs, no done; flush has priority over start and beat completion.
REQ-037 Beat counter wraps never: len=2^LEN_W-1 is the maximum burst.

Reset
REQ-038 sys_rst=1 asynchronously forces IDLE, clears captured config, beat counter, all data outputs, all _vld, busy and done to 0.
REQ-039 Reset mid-burst abandons the burst; first start after deassertion behaves as from power-up.

Configuration
REQ-040 Macro CB_ROUTE_REV_EN defined: dir=10 performs REQ-031 reverse mapping.
REQ-041 CB_ROUTE_REV_EN undefined: dir=10 behaves as dir=IDLE (REQ-033) and no reverse-index logic is synthesised.

Verification (L=X=Y=4, RSA_DW=16, RD_LAT=1; CB lanes 3..0 = 0x0044,0x0033,0x0022,0x0011)
REQ-042 start, dest=A, dir=POS, offset=1, nlanes=4, len=3 -> A lanes 3..0 = 0x0011,0x0044,0x0033,0x0022 with A_vld on edges 1-3, done at beat 3, B/M zero.
REQ-043 dest=B, dir=REV, offset=2, nlanes=3, len=1 (macro defined) -> B lanes 3..0 = 0,0x0033,0x0044,0x0011; macro undefined -> B=0, B_vld=0, done=1.
REQ-044 dest=M, dir=NEW, offset=3, len=2 -> M lanes 3..0 = 0,0,0x0011,0x0044 for 2 beats, M_vld=1.
REQ-045 len=5 burst, flush at beat 2 -> only 2 valid beats, outputs 0 next edge, done never asserted, busy=0.
REQ-046 start during busy, then sys_rst pulse mid-burst -> second start ignored; all outputs 0 immediately on reset, no done.
REQ-047 RD_LAT=3, len=1 -> A_vld asserted exactly at 3rd edge after start, busy high edges 1-3.
